ascon_ctrl_fsm: RTL

- Main sequencer for the ASCON-128 encryption datapath.
- Drives the permutation round index, the state-register enable, the input mux and the XOR-insertion enables through init (p12), associated data (p6 per block), plaintext (p6 per block) and finalization (p12).
- Sits beside the permutation datapath. It owns the round counter and the block counter and handshakes data blocks with the top-level stimulus source.

---
 rtl/ascon_ctrl_fsm_pkg.sv | 28 ++
 rtl/ascon_ctrl_fsm_round_cnt.sv | 30 +++
 rtl/ascon_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and round constants for the ASCON-128 encryption sequencer.
package ascon_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_AD = 3'd2,
    ST_AD      = 3'd3,
    ST_WAIT_PT = 3'd4,
    ST_PT      = 3'd5,
    ST_FIN     = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [3:0] ROUND_P12_START = 4'd0;
  localparam logic [3:0] ROUND_P6_START  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;
  // Counter value following an accept cycle, which already ran the first round
  localparam logic [3:0] ROUND_P12_NEXT  = 4'd1;
  localparam logic [3:0] ROUND_P6_NEXT   = 4'd7;

  function automatic int blk_cnt_width(input int nb_ad, input int nb_pt);
    int nb_max;
    nb_max = (nb_ad > nb_pt) ? nb_ad : nb_pt;
    return $clog2(nb_max + 1);
  endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_cnt.sv
// Permutation round index counter: load has priority, increment saturates at the last round.
module ascon_round_cnt
  import ascon_ctrl_fsm_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] cnt_o
);

  logic [3:0] cnt_r;

  // Round index register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_r <= 4'd0;
    end else if (load_i) begin
      cnt_r <= load_val_i;
    end else if (en_i && (cnt_r != ROUND_LAST)) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: init p12, AD and PT blocks with p6, finalization p12, tag.
module ascon_ctrl_fsm
  import ascon_ctrl_fsm_pkg::*;
#(
  parameter int NB_AD = 1,
  parameter int NB_PT = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       perm_en_o,
  output logic       input_sel_o,
  output logic       xor_begin_data_o,
  output logic       xor_begin_key_o,
  output logic       xor_end_key_o,
  output logic       xor_end_lsb_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       end_o,
  output logic       busy_o
);

  localparam int BCW = blk_cnt_width(NB_AD, NB_PT);
  localparam logic [BCW-1:0] AD_LAST_IDX = BCW'(NB_AD - 1);
  localparam logic [BCW-1:0] PT_LAST_IDX = BCW'(NB_PT - 1);
  localparam logic [BCW-1:0] BLK_ONE     = BCW'(1);
  localparam logic [BCW-1:0] BLK_ZERO    = BCW'(0);
  // A single PT block is also the last one, so its accept runs round 0 of finalization
  localparam logic [3:0] PT_ENTRY_ROUND  = (NB_PT == 1) ? ROUND_P12_START : ROUND_P6_START;

  state_t         state_r, state_nxt_s;
  logic [BCW-1:0] block_cnt_r, block_cnt_nxt_s;
  logic [3:0]     cnt_s;
  logic           cnt_load_s;
  logic [3:0]     cnt_load_val_s;
  logic           last_round_s;

  logic data_ready_s, perm_en_s, input_sel_s, xor_begin_data_s, xor_begin_key_s;
  logic xor_end_key_s, xor_end_lsb_s, cipher_valid_s, tag_valid_s, end_s;

  ascon_round_cnt u_round_cnt (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .en_i       (perm_en_s),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_load_val_s),
    .cnt_o      (cnt_s)
  );

  assign last_round_s = (cnt_s == ROUND_LAST);

  // State and block counter registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      block_cnt_r <= BLK_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      block_cnt_r <= block_cnt_nxt_s;
    end
  end

  // Next state, block counter and round counter loads
  always_comb begin
    state_nxt_s     = state_r;
    block_cnt_nxt_s = block_cnt_r;
    cnt_load_s      = 1'b0;
    cnt_load_val_s  = ROUND_P12_START;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s    = ST_INIT;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = ROUND_P12_NEXT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (last_round_s) begin
          state_nxt_s    = ST_WAIT_AD;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = ROUND_P6_START;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_WAIT_AD: begin
        if (data_valid_i) begin
          state_nxt_s    = ST_AD;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = ROUND_P6_NEXT;
        end else begin
          state_nxt_s = ST_WAIT_AD;
        end
      end
      ST_AD: begin
        if (last_round_s && (block_cnt_r == AD_LAST_IDX)) begin
          state_nxt_s     = ST_WAIT_PT;
          block_cnt_nxt_s = BLK_ZERO;
          cnt_load_s      = 1'b1;
          cnt_load_val_s  = PT_ENTRY_ROUND;
        end else if (last_round_s) begin
          state_nxt_s     = ST_WAIT_AD;
          block_cnt_nxt_s = block_cnt_r + BLK_ONE;
          cnt_load_s      = 1'b1;
          cnt_load_val_s  = ROUND_P6_START;
        end else begin
          state_nxt_s = ST_AD;
        end
      end
      ST_WAIT_PT: begin
        if (data_valid_i && (block_cnt_r == PT_LAST_IDX)) begin
          state_nxt_s    = ST_FIN;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = ROUND_P12_NEXT;
        end else if (data_valid_i) begin
          state_nxt_s    = ST_PT;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = ROUND_P6_NEXT;
        end else begin
          state_nxt_s = ST_WAIT_PT;
        end
      end
      ST_PT: begin
        if (last_round_s) begin
          state_nxt_s     = ST_WAIT_PT;
          block_cnt_nxt_s = block_cnt_r + BLK_ONE;
          cnt_load_s      = 1'b1;
          cnt_load_val_s  = ((block_cnt_r + BLK_ONE) == PT_LAST_IDX) ? ROUND_P12_START
                                                                      : ROUND_P6_START;
        end else begin
          state_nxt_s = ST_PT;
        end
      end
      ST_FIN: begin
        if (last_round_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FIN;
        end
      end
      ST_DONE: begin
        state_nxt_s     = ST_IDLE;
        block_cnt_nxt_s = BLK_ZERO;
        cnt_load_s      = 1'b1;
        cnt_load_val_s  = ROUND_P12_START;
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        block_cnt_nxt_s = BLK_ZERO;
        cnt_load_s      = 1'b1;
        cnt_load_val_s  = ROUND_P12_START;
      end
    endcase
  end

  // Datapath controls: Moore on state/round, Mealy on start/data_valid in accept cycles
  always_comb begin
    data_ready_s     = 1'b0;
    perm_en_s        = 1'b0;
    input_sel_s      = 1'b0;
    xor_begin_data_s = 1'b0;
    xor_begin_key_s  = 1'b0;
    xor_end_key_s    = 1'b0;
    xor_end_lsb_s    = 1'b0;
    cipher_valid_s   = 1'b0;
    tag_valid_s      = 1'b0;
    end_s            = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          perm_en_s = 1'b1;
        end else begin
          perm_en_s = 1'b0;
        end
      end
      ST_INIT, ST_FIN: begin
        perm_en_s   = 1'b1;
        input_sel_s = 1'b1;
        if (last_round_s) begin
          xor_end_key_s = 1'b1;
        end else begin
          xor_end_key_s = 1'b0;
        end
      end
      ST_WAIT_AD: begin
        data_ready_s = 1'b1;
        if (data_valid_i) begin
          perm_en_s        = 1'b1;
          input_sel_s      = 1'b1;
          xor_begin_data_s = 1'b1;
        end else begin
          perm_en_s = 1'b0;
        end
      end
      ST_AD: begin
        perm_en_s   = 1'b1;
        input_sel_s = 1'b1;
        if (last_round_s && (block_cnt_r == AD_LAST_IDX)) begin
          xor_end_lsb_s = 1'b1;
        end else begin
          xor_end_lsb_s = 1'b0;
        end
      end
      ST_WAIT_PT: begin
        data_ready_s = 1'b1;
        if (data_valid_i) begin
          perm_en_s        = 1'b1;
          input_sel_s      = 1'b1;
          xor_begin_data_s = 1'b1;
          cipher_valid_s   = 1'b1;
          xor_begin_key_s  = (block_cnt_r == PT_LAST_IDX);
        end else begin
          perm_en_s = 1'b0;
        end
      end
      ST_PT: begin
        perm_en_s   = 1'b1;
        input_sel_s = 1'b1;
      end
      ST_DONE: begin
        tag_valid_s = 1'b1;
        end_s       = 1'b1;
      end
      default: begin
        perm_en_s = 1'b0;
      end
    endcase
  end

  assign data_ready_o     = data_ready_s;
  assign round_o          = cnt_s;
  assign perm_en_o        = perm_en_s;
  assign input_sel_o      = input_sel_s;
  assign xor_begin_data_o = xor_begin_data_s;
  assign xor_begin_key_o  = xor_begin_key_s;
  assign xor_end_key_o    = xor_end_key_s;
  assign xor_end_lsb_o    = xor_end_lsb_s;
  assign cipher_valid_o   = cipher_valid_s;
  assign tag_valid_o      = tag_valid_s;
  assign end_o            = end_s;
  assign busy_o           = (state_r != ST_IDLE);

endmodule
